// File: rtl/rr_rsp_router.sv
// rr_rsp_router: response-return companion of a round-robin arbitration tree.
// Records the winning index of every accepted request in an in-order tracking
// FIFO, throttles requests when the FIFO is full, and steers each in-order
// downstream response back to the master that issued the request.
// Optional feature macro: RR_RSP_ROUTER_OUT_REG_EN inserts a 2-entry spill
// register (data + index) in front of the rsp_*_o outputs.
module rr_rsp_router #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTxns   = 8,
    parameter int unsigned IdxWidth  = $clog2(NumOut),
    parameter int unsigned CntWidth  = $clog2(MaxTxns + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 req_ready_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_data_i,
    output logic                 rsp_ready_o,
    output logic [NumOut-1:0]    rsp_valid_o,
    output logic [DataWidth-1:0] rsp_data_o,
    input  logic [NumOut-1:0]    rsp_ready_i,
    output logic [CntWidth-1:0]  outstanding_o
);

    localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxTxns - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxTxns);

    // Circular pointer increment; wraps at the last slot so any depth works.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == LastPtr) begin
            return {PtrWidth{1'b0}};
        end else begin
            return p + PtrWidth'(1);
        end
    endfunction

    // One-hot decode of a master index; out-of-range indices select nobody.
    function automatic logic [NumOut-1:0] idx_decode(input logic [IdxWidth-1:0] idx);
        logic [NumOut-1:0] sel;
        sel = {NumOut{1'b0}};
        for (int i = 0; i < int'(NumOut); i++) begin
            if (idx == IdxWidth'(i)) begin
                sel[i] = 1'b1;
            end else begin
                sel[i] = 1'b0;
            end
        end
        return sel;
    endfunction

    logic [IdxWidth-1:0] idx_mem_r [MaxTxns];
    logic [PtrWidth-1:0] wr_ptr_r;
    logic [PtrWidth-1:0] rd_ptr_r;
    logic [CntWidth-1:0] cnt_r;

    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic [IdxWidth-1:0] head_idx_s;
    logic [NumOut-1:0]   head_sel_s;

    // full/empty come from registered state only, so the response side never
    // reaches the request side combinationally.
    assign full_s     = (cnt_r == FullCnt);
    assign empty_s    = (cnt_r == {CntWidth{1'b0}});
    assign head_idx_s = idx_mem_r[rd_ptr_r];
    assign head_sel_s = idx_decode(head_idx_s);

    assign req_valid_o   = req_valid_i & ~full_s;
    assign req_ready_o   = req_ready_i & ~full_s;
    assign push_s        = req_valid_i & req_ready_i & ~full_s;
    assign pop_s         = rsp_valid_i & rsp_ready_o;
    assign outstanding_o = cnt_r;

    // Pointer and fill-level bookkeeping; flush discards same-cycle push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
            cnt_r    <= {CntWidth{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
            cnt_r    <= {CntWidth{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CntWidth'(1);
                2'b01:   cnt_r <= cnt_r - CntWidth'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Tracking storage: the winning index of each accepted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MaxTxns); i++) begin
                idx_mem_r[i] <= {IdxWidth{1'b0}};
            end
        end else if (push_s && !flush_i) begin
            idx_mem_r[wr_ptr_r] <= req_idx_i;
        end
    end

`ifdef RR_RSP_ROUTER_OUT_REG_EN
    logic [DataWidth-1:0] sp_data_r [2];
    logic [IdxWidth-1:0]  sp_idx_r  [2];
    logic                 sp_wr_r;
    logic                 sp_rd_r;
    logic [1:0]           sp_cnt_r;
    logic                 sp_push_s;
    logic                 sp_pop_s;
    logic [NumOut-1:0]    sp_sel_s;

    // Input side accepts whenever the spill has room; illegal heads are never taken.
    assign rsp_ready_o = (sp_cnt_r != 2'd2) & ~empty_s & (|head_sel_s);
    assign sp_push_s   = pop_s;
    assign sp_sel_s    = idx_decode(sp_idx_r[sp_rd_r]);
    assign rsp_valid_o = sp_sel_s & {NumOut{sp_cnt_r != 2'd0}};
    assign rsp_data_o  = sp_data_r[sp_rd_r];
    assign sp_pop_s    = |(rsp_valid_o & rsp_ready_i);

    // Two-entry spill FIFO keeps full throughput with a registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_wr_r  <= 1'b0;
            sp_rd_r  <= 1'b0;
            sp_cnt_r <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                sp_data_r[i] <= {DataWidth{1'b0}};
                sp_idx_r[i]  <= {IdxWidth{1'b0}};
            end
        end else if (flush_i) begin
            sp_wr_r  <= 1'b0;
            sp_rd_r  <= 1'b0;
            sp_cnt_r <= 2'd0;
        end else begin
            if (sp_push_s) begin
                sp_data_r[sp_wr_r] <= rsp_data_i;
                sp_idx_r[sp_wr_r]  <= head_idx_s;
                sp_wr_r            <= ~sp_wr_r;
            end
            if (sp_pop_s) begin
                sp_rd_r <= ~sp_rd_r;
            end
            case ({sp_push_s, sp_pop_s})
                2'b10:   sp_cnt_r <= sp_cnt_r + 2'd1;
                2'b01:   sp_cnt_r <= sp_cnt_r - 2'd1;
                default: sp_cnt_r <= sp_cnt_r;
            endcase
        end
    end
`else
    // Zero-latency routing straight to the head master.
    assign rsp_valid_o = head_sel_s & {NumOut{rsp_valid_i & ~empty_s}};
    assign rsp_ready_o = (|(head_sel_s & rsp_ready_i)) & ~empty_s;
    assign rsp_data_o  = rsp_data_i;
`endif

endmodule
